// File: rtl/mp_sub_seq_if.sv
// Request/response and rca_sub-facing signal bundle for mp_sub_seq.
// The slave modport is the sequencer; master is whoever drives requests and hosts rca_sub.
interface mp_sub_seq_if #(
    parameter int unsigned NWORDS = 4
);
    localparam int unsigned W = 16 * NWORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         borrow;
    logic         zero;
    logic [15:0]  sub_in0;
    logic [15:0]  sub_in1;
    logic         sub_bin;
    logic [15:0]  sub_res;
    logic         sub_bout;

    modport master (
        output start, a, b, bin_in, sub_res, sub_bout,
        input  busy, done, result, borrow, zero, sub_in0, sub_in1, sub_bin
    );

    modport slave (
        input  start, a, b, bin_in, sub_res, sub_bout,
        output busy, done, result, borrow, zero, sub_in0, sub_in1, sub_bin
    );
endinterface

// File: rtl/mp_sub_seq.sv
// Multi-precision subtract sequencer: streams NWORDS 16-bit words LSW first through an
// external rca_sub, chaining the borrow, and assembles the wide difference, borrow and zero.
module mp_sub_seq #(
    parameter int unsigned NWORDS = 4
) (
    input logic          clk,
    input logic          rst,
    mp_sub_seq_if.slave  bus
);
    localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e                    state_q;
    logic [IdxW-1:0]           idx_q;
    logic [NWORDS-1:0][15:0]   a_q;
    logic [NWORDS-1:0][15:0]   b_q;
    logic                      bin_q;
    logic                      chain_q;
    logic                      zacc_q;
    logic [NWORDS-1:0][15:0]   result_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      borrow_q;
    logic                      zero_q;

    logic                      word_zero;
    logic                      last_word;

    assign word_zero = (bus.sub_res == 16'h0000);
    assign last_word = (idx_q == IdxW'(NWORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bin_q    <= 1'b0;
            chain_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        bin_q    <= bus.bin_in;
                        result_q <= '0;
                        zacc_q   <= 1'b1;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    result_q[idx_q] <= bus.sub_res;
                    chain_q         <= bus.sub_bout;
                    zacc_q          <= zacc_q & word_zero;
                    if (last_word) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        borrow_q <= bus.sub_bout;
                        zero_q   <= zacc_q & word_zero;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Word 0 takes the caller's borrow; later words take the previous word's borrow-out.
    always_comb begin
        bus.sub_in0 = 16'h0000;
        bus.sub_in1 = 16'h0000;
        bus.sub_bin = 1'b0;
        if (state_q == StRun) begin
            bus.sub_in0 = a_q[idx_q];
            bus.sub_in1 = b_q[idx_q];
            bus.sub_bin = (idx_q == '0) ? bin_q : chain_q;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_mp_sub_seq.sv
// Scoreboard bench for mp_sub_seq with a behavioural rca_sub and wide-arithmetic reference.
module tb_mp_sub_seq;
    localparam int unsigned NW = 4;
    localparam int unsigned W  = 16 * NW;

    typedef struct packed {
        logic [W-1:0] result;
        logic         borrow;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    mp_sub_seq_if #(.NWORDS(NW)) bus ();

    mp_sub_seq #(.NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // rca_sub stand-in: in0 - in1 - bin, bout on underflow
    logic [16:0] rca_diff;
    assign rca_diff     = {1'b0, bus.sub_in0} - {1'b0, bus.sub_in1} - {16'b0, bus.sub_bin};
    assign bus.sub_res  = rca_diff[15:0];
    assign bus.sub_bout = rca_diff[16];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] d;
        exp_t e;
        d = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.result = d[W-1:0];
        e.borrow = d[W];
        e.zero   = (d[W-1:0] == '0);
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse and checks pulse width.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result", bus.result, e.result);
                chk("borrow", {63'b0, bus.borrow}, {63'b0, e.borrow});
                chk("zero", {63'b0, bus.zero}, {63'b0, e.zero});
            end
            if (done_prev) chk("done_width", 2, 1);
        end
        done_prev = bus.done;
    end

    // Issue one op starting #1 after a posedge while IDLE; checks busy/done timing.
    // With poke set, a second start with a different a is pulsed mid-run.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit poke);
        bus.a      = a;
        bus.b      = b;
        bus.bin_in = bin;
        bus.start  = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, bin));
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = a;
        chk("busy_e0", {63'b0, bus.busy}, 64'd1);
        chk("done_e0", {63'b0, bus.done}, 64'd0);
        for (int k = 1; k <= int'(NW); k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 1) begin
                bus.start = 1'b1;
                bus.a     = {$urandom, $urandom};
            end
            if (poke && k == 2) bus.start = 1'b0;
            if (k < int'(NW)) begin
                chk("busy_run", {63'b0, bus.busy}, 64'd1);
            end else begin
                chk("busy_end", {63'b0, bus.busy}, 64'd0);
                chk("done_end", {63'b0, bus.done}, 64'd1);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd0);
        chk({tag, "_done"}, {63'b0, bus.done}, 64'd0);
        chk({tag, "_result"}, bus.result, 64'd0);
        chk({tag, "_borrow"}, {63'b0, bus.borrow}, 64'd0);
        chk({tag, "_zero"}, {63'b0, bus.zero}, 64'd0);
        chk({tag, "_sub_in"}, {31'b0, bus.sub_bin, bus.sub_in1, bus.sub_in0}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.bin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        op(64'h0000_0000_0001_0000, 64'd1, 1'b0, 1'b0);
        op(64'd0, 64'd1, 1'b0, 1'b0);
        op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        op(64'hDEAD_BEEF_0000_1111, 64'h0000_0000_2222_3333, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // Abort mid-run at idx=2; no done may follow.
        bus.a     = 64'hFFFF_0000_FFFF_0000;
        bus.b     = 64'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_cleared("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        op(64'd100, 64'd50, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
